alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width in bits; legal values are 8, 16, 32 and 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), SHALL set the number of operand-B bits used as the shift amount.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 valid_i  input  1  SHALL mark an operation request.
REQ-006 ready_o  output  1  SHALL indicate the unit accepts a request this cycle.
REQ-007 op_i  input  4  SHALL select the operation.
REQ-008 a_i, b_i  input  WIDTH  SHALL be operands A and B.
REQ-009 flush_i  input  1  SHALL abort any in-flight operation.
REQ-010 valid_o  output  1  SHALL be a one-cycle result-valid pulse.
REQ-011 res_o  output  WIDTH  SHALL be the registered result, held until the next valid_o.
REQ-012 busy_o  output  1  SHALL be high while a multi-cycle operation iterates.

Function
REQ-013 Op encoding SHALL be: 0000 add, 0001 sub, 0010 sll, 0011 slt (signed), 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and, 1010 mul (low WIDTH bits), 1011 mulhu (high WIDTH bits, unsigned), 1100 divu, 1101 remu, 1111 pass B; 1110 SHALL return 0.
REQ-014 Shifts SHALL use only b_i[SHW-1:0]; sra SHALL replicate a_i[WIDTH-1].
REQ-015 slt/sltu SHALL return zero-extended 0 or 1; add/sub SHALL wrap modulo 2^WIDTH.
REQ-016 A request is accepted in a cycle where valid_i and ready_o are both 1; operands and op SHALL be captured on acceptance.
REQ-017 FSM states SHALL be IDLE, ITER, DONE; ready_o = 1 only in IDLE.
REQ-018 Single-cycle ops: IDLE->DONE on acceptance; valid_o SHALL assert exactly 1 cycle after acceptance.
REQ-019 mul/mulhu/divu/remu: IDLE->ITER on acceptance, one shift-add or restoring-divide step per cycle for WIDTH cycles, then ->DONE; valid_o SHALL assert WIDTH+1 cycles after acceptance.
REQ-020 DONE SHALL drive valid_o = 1 for one cycle, load res_o in the same cycle, and return to IDLE; no back-to-back acceptance occurs in the DONE cycle.
REQ-021 divu by zero SHALL return all ones; remu by zero SHALL return a_i; both take the full WIDTH+1 latency.
REQ-022 busy_o SHALL equal (state == ITER).
REQ-023 valid_i while ready_o = 0 SHALL be ignored, with no effect on state or outputs.
REQ-024 flush_i SHALL return the FSM to IDLE next cycle from any state, suppress the pending valid_o, and leave res_o unchanged; flush_i together with valid_i in IDLE SHALL not accept.

Reset
REQ-025 On rst, state SHALL be IDLE, ready_o = 1, valid_o = 0, busy_o = 0, res_o = 0, and all iteration registers SHALL be 0.
REQ-026 rst asserted mid-ITER SHALL discard the operation with no valid_o; rst SHALL take priority over flush_i and valid_i.

Configuration
REQ-027 Macro ALU_SEQ_MULDIV_EN defined: ops 1010-1101 SHALL behave per REQ-019/021.
REQ-028 Macro ALU_SEQ_MULDIV_EN undefined: ops 1010-1101 SHALL complete as single-cycle ops returning 0, the ITER state and iteration datapath SHALL be absent, and busy_o SHALL be tied 0.

Verification
REQ-029 WIDTH=32, op 0000, a=0xFFFFFFFF, b=1 -> valid_o 1 cycle later, res_o=0x00000000.
REQ-030 WIDTH=32, op 0111, a=0x80000000, b=0x00000024 (shift amount 4) -> res_o=0xF8000000.
REQ-031 MULDIV_EN, op 1010 a=7 b=6 -> busy_o high for 32 cycles, valid_o at cycle 33, res_o=42; op 1011 a=b=0xFFFFFFFF -> res_o=0xFFFFFFFE.
REQ-032 MULDIV_EN, op 1100 a=100 b=0 -> res_o=0xFFFFFFFF; op 1101 a=100 b=7 -> res_o=2.
REQ-033 MULDIV_EN, accept divu, pulse flush_i at cycle 10 -> no valid_o, ready_o=1 next cycle, res_o unchanged; a valid_i during ITER is ignored.
REQ-034 WIDTH=8, op 0010 a=0x01 b=0x0B -> res_o=0x08; rst mid-ITER -> all outputs at reset values the following cycle.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus optional iterative mul/div.
// Define ALU_SEQ_MULDIV_EN to enable the shift-add multiplier and restoring divider.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] res_o,
  output logic             busy_o
);

`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

  state_t           state, state_n;
  logic             accept;
  logic             is_multi;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] res_q;

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH:0]   sum, diff;
  logic             last;

  assign is_multi = (op_i >= 4'd10) && (op_i <= 4'd13);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign busy_o   = (state == ITER);

  // hi:lo is the product (mul) or remainder:quotient (div); one step per cycle
  always_comb begin
    sum  = '0;
    diff = '0;
    hi_n = hi;
    lo_n = lo;
    if (op_q[1]) begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end else begin
      diff = {hi, lo[WIDTH-1]} - {1'b0, m};
      lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
      hi_n = diff[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : diff[WIDTH-1:0];
    end
  end
`else
  assign is_multi = 1'b0;
  assign busy_o   = 1'b0;
`endif

  assign shamt = b_i[SHW-1:0];
  assign res_o = res_q;

  always_comb begin
    alu_res = '0;
    case (op_i)
      4'b0000: alu_res = a_i + b_i;
      4'b0001: alu_res = a_i - b_i;
      4'b0010: alu_res = a_i << shamt;
      4'b0011: alu_res[0] = $signed(a_i) < $signed(b_i);
      4'b0100: alu_res[0] = a_i < b_i;
      4'b0101: alu_res = a_i ^ b_i;
      4'b0110: alu_res = a_i >> shamt;
      4'b0111: alu_res = $signed(a_i) >>> shamt;
      4'b1000: alu_res = a_i | b_i;
      4'b1001: alu_res = a_i & b_i;
      4'b1111: alu_res = b_i;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
    accept  = valid_i && ready_o && !flush_i;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
          state_n = is_multi ? ITER : DONE;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      ITER: if (last) state_n = DONE;
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      cnt   <= '0;
      op_q  <= '0;
`endif
    end else begin
      if (accept && !is_multi) res_q <= alu_res;
`ifdef ALU_SEQ_MULDIV_EN
      if (accept && is_multi) begin
        op_q <= op_i[1:0];
        cnt  <= '0;
        hi   <= '0;
        m    <= op_i[1] ? a_i : b_i;
        lo   <= op_i[1] ? b_i : a_i;
      end
      if (state == ITER && !flush_i) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + 1'b1;
        if (last) res_q <= op_q[0] ? hi_n : lo_n;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: cycle-level reference model plus directed literal vectors.
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MLAT  = MD ? 33 : 1;
  localparam int MLAT8 = MD ? 9 : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0, flush_i = 1'b0;
  logic [3:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] res_o;

  logic        v8 = 1'b0;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, vo8, busy8;
  logic [7:0]  res8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .valid_o(valid_o), .res_o(res_o), .busy_o(busy_o)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .valid_i(v8), .ready_o(rdy8), .op_i(op8),
    .a_i(a8), .b_i(b8), .flush_i(1'b0), .valid_o(vo8), .res_o(res8), .busy_o(busy8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op);
    return (MD && op >= 4'd10 && op <= 4'd13) ? 33 : 1;
  endfunction

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [63:0] p;
    logic [31:0] r;
    sh = b[4:0];
    p  = {32'b0, a} * {32'b0, b};
    r  = '0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a << sh;
      4'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  r = (a < b) ? 32'd1 : 32'd0;
      4'd5:  r = a ^ b;
      4'd6:  r = a >> sh;
      4'd7:  begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: r = MD ? p[31:0] : 32'd0;
      4'd11: r = MD ? p[63:32] : 32'd0;
      4'd12: r = !MD ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: r = !MD ? 32'd0 : (b == 0) ? a : a % b;
      4'd15: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Reference model: tracks cycles since acceptance of the one outstanding request
  bit          m_pend = 1'b0;
  int          m_since = 0, m_lat = 1;
  logic [31:0] m_pr = '0, m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 1'b0;
      m_res  = '0;
    end else if (m_pend && m_since == m_lat) begin
      m_pend = 1'b0;
    end else if (m_pend && flush_i) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_since++;
      if (m_since == m_lat) m_res = m_pr;
    end else if (valid_i && !flush_i) begin
      m_pend  = 1'b1;
      m_since = 1;
      m_lat   = lat_of(op_i);
      m_pr    = model(op_i, a_i, b_i);
      if (m_lat == 1) m_res = m_pr;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ready", ready_o, !m_pend);
      chk("model_valid", valid_o, m_pend && m_since == m_lat);
      chk("model_busy",  busy_o,  m_pend && m_since < m_lat);
      chk("model_res",   res_o,   m_res);
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int n, nbusy;
    bit seen;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    n = 1; nbusy = 0; seen = 1'b0;
    while (!seen && n <= 60) begin
      if (valid_o) seen = 1'b1;
      else begin
        if (busy_o) nbusy++;
        @(negedge clk);
        n++;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_res"}, res_o, exp);
      chk({name, "_lat"}, n, exp_lat);
      chk({name, "_busycyc"}, nbusy, exp_lat - 1);
    end
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input string name);
    @(negedge clk);
    op8 = op; a8 = a; b8 = b; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    chk({name, "_valid"}, vo8, 1);
    chk({name, "_res"}, res8, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy",  busy_o,  0);
    chk("rst_res",   res_o,   0);
    rst = 1'b0;

    run_op(4'b0000, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1, "add_wrap");
    run_op(4'b0001, 32'd5,         32'd7,        32'hFFFF_FFFE, 1, "sub_wrap");
    run_op(4'b0010, 32'd1,         32'h0000_002B, 32'h0000_0800, 1, "sll");
    run_op(4'b0011, 32'h8000_0000, 32'd1,        32'd1,         1, "slt");
    run_op(4'b0100, 32'h8000_0000, 32'd1,        32'd0,         1, "sltu");
    run_op(4'b0101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1, "xor");
    run_op(4'b0110, 32'h8000_0000, 32'd4,        32'h0800_0000, 1, "srl");
    run_op(4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, "sra");
    run_op(4'b1000, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, 1, "or");
    run_op(4'b1001, 32'h0000_0FF0, 32'h0000_00FF, 32'h0000_00F0, 1, "and");
    run_op(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1, "op1110");
    run_op(4'b1111, 32'd1,         32'h0000_1234, 32'h0000_1234, 1, "passb");
    run_op(4'b1010, 32'd7,         32'd6,        MD ? 32'd42 : 32'd0,          MLAT, "mul");
    run_op(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD ? 32'hFFFF_FFFE : 32'd0,  MLAT, "mulhu");
    run_op(4'b1100, 32'd100,       32'd0,        MD ? 32'hFFFF_FFFF : 32'd0,   MLAT, "divu_zero");
    run_op(4'b1101, 32'd100,       32'd7,        MD ? 32'd2 : 32'd0,           MLAT, "remu");
    run_op(4'b1101, 32'd100,       32'd0,        MD ? 32'd100 : 32'd0,         MLAT, "remu_zero");
    run_op(4'b1100, 32'd100,       32'd7,        MD ? 32'd14 : 32'd0,          MLAT, "divu");

    // Request held high through busy/done cycles: extra requests only land when ready
    @(negedge clk);
    op_i = 4'b1100; a_i = 32'd1000; b_i = 32'd3; valid_i = 1'b1;
    @(negedge clk);
    op_i = 4'b0000; a_i = 32'd11;
    repeat (4) @(negedge clk);
    valid_i = 1'b0;
    repeat (MLAT + 4) @(negedge clk);

    // flush with valid in IDLE must not accept
    run_op(4'b1111, 32'd0, 32'h0000_BEEF, 32'h0000_BEEF, 1, "passb2");
    @(negedge clk);
    op_i = 4'b0000; a_i = 32'd1; b_i = 32'd1; valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle_ready", ready_o, 1);
    chk("flush_idle_valid", valid_o, 0);
    chk("flush_idle_res",   res_o,   32'h0000_BEEF);

    if (MD) begin
      // flush ten cycles into a divide
      op_i = 4'b1100; a_i = 32'd500; b_i = 32'd5; valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_iter_ready", ready_o, 1);
      chk("flush_iter_busy",  busy_o,  0);
      chk("flush_iter_res",   res_o,   32'h0000_BEEF);
      repeat (MLAT + 2) begin
        @(negedge clk);
        chk("flush_no_valid", valid_o, 0);
      end
    end

    run8(4'b0010, 8'h01, 8'h0B, 8'h08, "w8_sll");
    run8(4'b0000, 8'hFF, 8'h02, 8'h01, "w8_add");

    // reset mid-operation, with flush and valid also high
    run_op(4'b1111, 32'd0, 32'h0000_1234, 32'h0000_1234, 1, "passb3");
    @(negedge clk);
    if (MD) begin
      op_i = 4'b1010; a_i = 32'd9; b_i = 32'd9; valid_i = 1'b1;
      op8 = 4'b1010; a8 = 8'd3; b8 = 8'd3; v8 = 1'b1;
      @(negedge clk);
      valid_i = 1'b0; v8 = 1'b0;
      repeat (4) @(negedge clk);
      chk("w8_busy_mid", busy8, 1);
    end
    rst = 1'b1; valid_i = 1'b1; flush_i = 1'b1; v8 = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", ready_o, 1);
    chk("rstmid_valid", valid_o, 0);
    chk("rstmid_busy",  busy_o,  0);
    chk("rstmid_res",   res_o,   0);
    chk("w8_rst_ready", rdy8, 1);
    chk("w8_rst_valid", vo8, 0);
    chk("w8_rst_busy",  busy8, 0);
    chk("w8_rst_res",   res8, 0);
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; v8 = 1'b0;
    repeat (MLAT8 + 3) begin
      @(negedge clk);
      chk("w8_no_valid", vo8, 0);
    end
    run_op(4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, "sub_after_rst");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
